logic_unit_scheduler: RTL and testbench
=======================================

# logic_unit_scheduler

Round-robin scheduler that shares one combinational 32-bit bitwise logic unit (AND/OR/XOR datapath with enable gating) between NUM_REQ requesters. It owns the datapath's enable and operand/opcode inputs, and runs at most one operation at a time. Each result is registered and returned with the winning requester's ID over a valid/ready response channel. A saturating counter records completed operations.

## Interface
- WIDTH, 32: operand/result width.
- NUM_REQ, 4: number of requesters (2..8); ID width IDW = clog2(NUM_REQ).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero).
- req_op  in  2*NUM_REQ  opcode per requester, slice i = [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 illegal.
- req_a, req_b  in  WIDTH*NUM_REQ  operands per requester, slice i = [WIDTH*i+WIDTH-1:WIDTH*i].
- alu_en  out  1  datapath enable.
- alu_op  out  2  datapath opcode.
- alu_a, alu_b  out  WIDTH  datapath operands.
- alu_result  in  WIDTH  datapath combinational result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  WIDTH  result.
- rsp_id  out  IDW  index of the requester served.
- rsp_err  out  1  illegal opcode flag.
- op_count  out  16  completed-response count, saturating.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant winner g, the first set bit searching upward from rr_ptr, wrapping at NUM_REQ.
  - req_ready[g]=1 combinationally this cycle. A request is accepted when req_valid[g] and req_ready[g] are both high.
  - On accept, latch op/a/b/id into internal registers and set rr_ptr <= (g+1) mod NUM_REQ.
  - Next state: EXEC for legal opcodes. For opcode 11, go directly to RESP with rsp_data=0 and rsp_err=1; the datapath is never enabled.
- EXEC: alu_en=1; alu_op/alu_a/alu_b driven from the latched registers. At the clock edge, capture rsp_data <= alu_result and rsp_err <= 0, then go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data/rsp_id/rsp_err hold stable until rsp_ready.
  - On the handshake, op_count increments (saturates at 16'hFFFF) and the FSM returns to IDLE.
- Outside EXEC: alu_en=0, and alu_a/alu_b/alu_op are forced to 0 so datapath inputs stay quiet.
- req_ready is all-zero in EXEC and RESP. Requesters must hold req_valid and payload until granted.
- Requesters that drop req_valid before being granted are simply skipped. No request is buffered.

## Timing
- Reset values:
  - State IDLE, rr_ptr 0.
  - req_ready 0, alu_en 0, alu_op/alu_a/alu_b 0.
  - rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, op_count 0.
- Legal op latency: accept in cycle T, EXEC in T+1, rsp_valid in T+2.
- Illegal op latency: accept in T, rsp_valid in T+1.
- Minimum issue interval is 3 cycles (legal) or 2 cycles (illegal) with rsp_ready tied high.
- No new grant occurs in the cycle of the RESP handshake. The next grant is the cycle after it.
- rsp_ready low stalls indefinitely in RESP. No output may change while stalled.
- Reset asserted mid-operation (EXEC or RESP) discards the operation: no response is produced and op_count does not increment.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,... A requester waits at most NUM_REQ-1 other grants.
- Simultaneous events: when rr_ptr points at a non-requesting index, the search skips it. The pointer always moves to winner+1, never to rr_ptr+1.

## Test plan
- Single AND: req 1 valid with op 00, a=0xF0F0_1234, b=0x0FF0_FFFF, rsp_ready=1. Expect req_ready=4'b0010 in cycle T, alu_en=1 only in T+1, rsp_valid in T+2 with rsp_data=0x00F0_1234, rsp_id=1, rsp_err=0, op_count=1.
- Round-robin: all four requesters valid continuously with distinct operands. Expect grant order 0,1,2,3,0 at 3-cycle spacing, each rsp_id matching its operands' result (OR 0xA5000000|0x005A0000 -> 0xA55A0000, XOR 0xFFFF0000^0xFF00FF00 -> 0x00FFFF00).
- Illegal opcode: req 2 with op 11. Expect rsp_valid at T+1 with rsp_err=1, rsp_data=0, alu_en never high; op_count increments.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP. Expect rsp_* stable and req_ready=0 throughout. Raise rsp_ready: handshake occurs, next grant follows one cycle later.
- Reset mid-EXEC: assert rst during EXEC. Expect all outputs at reset values next cycle, no rsp_valid, op_count=0, and the next grant going to requester 0.
- Saturation: force 65,537 completed responses. Expect op_count to stay at 0xFFFF.

Source files
------------

// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler sharing one combinational bitwise logic unit among NUM_REQ requesters.
// One operation in flight; result returned with requester ID over a valid/ready channel.
module logic_unit_scheduler #(
   parameter  int WIDTH   = 32,
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [2*NUM_REQ-1:0]     req_op,
   input  logic [WIDTH*NUM_REQ-1:0] req_a,
   input  logic [WIDTH*NUM_REQ-1:0] req_b,
   output logic                     alu_en,
   output logic [1:0]               alu_op,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   input  logic [WIDTH-1:0]         alu_result,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [IDW-1:0]           rsp_id,
   output logic                     rsp_err,
   output logic [15:0]              op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam int            CW = IDW + 1;
   localparam logic [CW-1:0] NR = CW'(NUM_REQ);

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t             state_q, state_d;
   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
   logic               alu_en_q, alu_en_d;
   logic [1:0]         alu_op_q, alu_op_d;
   logic [WIDTH-1:0]   alu_a_q, alu_a_d;
   logic [WIDTH-1:0]   alu_b_q, alu_b_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic [IDW-1:0]     rsp_id_q, rsp_id_d;
   logic               rsp_err_q, rsp_err_d;
   logic [15:0]        op_count_q, op_count_d;

   logic               gnt_found;
   logic [IDW-1:0]     gnt_idx;
   logic [CW-1:0]      cand;
   logic [CW-1:0]      nxt_ptr;
   logic [1:0]         gnt_op;
   logic [WIDTH-1:0]   gnt_a, gnt_b;

   // Search downward so the candidate closest to rr_ptr is the last one written.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + CW'(k);
         if (cand >= NR) cand = cand - NR;
         if (req_valid[cand[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      nxt_ptr = {1'b0, gnt_idx} + CW'(1);
      if (nxt_ptr >= NR) nxt_ptr = '0;
      gnt_op = req_op[2*int'(gnt_idx) +: 2];
      gnt_a  = req_a[WIDTH*int'(gnt_idx) +: WIDTH];
      gnt_b  = req_b[WIDTH*int'(gnt_idx) +: WIDTH];
   end

   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && gnt_found && !rst) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      alu_en_d    = alu_en_q;
      alu_op_d    = alu_op_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      rsp_err_d   = rsp_err_q;
      op_count_d  = op_count_q;
      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               rr_ptr_d = nxt_ptr[IDW-1:0];
               rsp_id_d = gnt_idx;
               if (gnt_op == 2'b11) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d  = EXEC;
                  alu_en_d = 1'b1;
                  alu_op_d = gnt_op;
                  alu_a_d  = gnt_a;
                  alu_b_d  = gnt_b;
               end
            end
         end
         EXEC: begin
            state_d     = RESP;
            rsp_data_d  = alu_result;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            alu_en_d    = 1'b0;
            alu_op_d    = '0;
            alu_a_d     = '0;
            alu_b_d     = '0;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               op_count_d  = sat_inc(op_count_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         alu_en_q    <= 1'b0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         rsp_err_q   <= 1'b0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         alu_en_q    <= alu_en_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         rsp_err_q   <= rsp_err_d;
         op_count_q  <= op_count_d;
      end
   end

   assign alu_en    = alu_en_q;
   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_err   = rsp_err_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Directed bench for logic_unit_scheduler with a stand-in AND/OR/XOR datapath.
module tb_logic_unit_scheduler;
   localparam int W   = 32;
   localparam int N   = 4;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [2*N-1:0]   req_op;
   logic [W*N-1:0]   req_a;
   logic [W*N-1:0]   req_b;
   logic             alu_en;
   logic [1:0]       alu_op;
   logic [W-1:0]     alu_a;
   logic [W-1:0]     alu_b;
   logic [W-1:0]     alu_result;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [W-1:0]     rsp_data;
   logic [IDW-1:0]   rsp_id;
   logic             rsp_err;
   logic [15:0]      op_count;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_rr [4] = '{32'h1234_0000, 32'hA55A_0000, 32'h00FF_FF00, 32'h0F0F_0000};

   always #5 clk = ~clk;

   logic_unit_scheduler #(.WIDTH(W), .NUM_REQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .rsp_err(rsp_err), .op_count(op_count)
   );

   always_comb begin
      alu_result = '0;
      if (alu_en) begin
         case (alu_op)
            2'b00:   alu_result = alu_a & alu_b;
            2'b01:   alu_result = alu_a | alu_b;
            2'b10:   alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[2*i +: 2] = op;
      req_a[W*i +: W]  = a;
      req_b[W*i +: W]  = b;
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      tick(); tick(); settle();
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_alu_en",    32'(alu_en),    32'h0);
      chk("rst_alu_op",    32'(alu_op),    32'h0);
      chk("rst_alu_a",     alu_a,          32'h0);
      chk("rst_alu_b",     alu_b,          32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data",  rsp_data,       32'h0);
      chk("rst_rsp_id",    32'(rsp_id),    32'h0);
      chk("rst_rsp_err",   32'(rsp_err),   32'h0);
      chk("rst_op_count",  32'(op_count),  32'h0);

      // Single AND on requester 1
      tick(); rst = 1'b0;
      set_req(1, 2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF);
      req_valid = 4'b0010; settle();
      chk("and_ready_T", 32'(req_ready), 32'h2);
      chk("and_en_T",    32'(alu_en),    32'h0);
      tick(); req_valid = '0; settle();
      chk("and_en_T1",    32'(alu_en),    32'h1);
      chk("and_op_T1",    32'(alu_op),    32'h0);
      chk("and_a_T1",     alu_a,          32'hF0F0_1234);
      chk("and_b_T1",     alu_b,          32'h0FF0_FFFF);
      chk("and_vld_T1",   32'(rsp_valid), 32'h0);
      chk("and_ready_T1", 32'(req_ready), 32'h0);
      tick(); settle();
      chk("and_vld_T2",  32'(rsp_valid), 32'h1);
      chk("and_data_T2", rsp_data,       32'h00F0_1234);
      chk("and_id_T2",   32'(rsp_id),    32'h1);
      chk("and_err_T2",  32'(rsp_err),   32'h0);
      chk("and_en_T2",   32'(alu_en),    32'h0);
      chk("and_a_T2",    alu_a,          32'h0);
      tick(); settle();
      chk("and_vld_T3",  32'(rsp_valid), 32'h0);
      chk("and_cnt_T3",  32'(op_count),  32'h1);

      // Reset during EXEC of requester 3 (pointer at 2 is skipped)
      set_req(3, 2'b00, 32'h0F0F_0F0F, 32'hFFFF_0000);
      req_valid = 4'b1000; settle();
      chk("skip_ready", 32'(req_ready), 32'h8);
      tick(); settle();
      chk("mid_en", 32'(alu_en), 32'h1);
      rst = 1'b1;
      set_req(0, 2'b00, 32'hFFFF_0000, 32'h1234_5678);
      set_req(1, 2'b01, 32'hA500_0000, 32'h005A_0000);
      set_req(2, 2'b10, 32'hFFFF_0000, 32'hFF00_FF00);
      req_valid = 4'b1111;
      tick(); settle();
      chk("mrst_en",    32'(alu_en),    32'h0);
      chk("mrst_a",     alu_a,          32'h0);
      chk("mrst_vld",   32'(rsp_valid), 32'h0);
      chk("mrst_id",    32'(rsp_id),    32'h0);
      chk("mrst_cnt",   32'(op_count),  32'h0);
      chk("mrst_ready", 32'(req_ready), 32'h0);
      rst = 1'b0; settle();

      // Round robin with all requesters valid
      for (int k = 0; k < 5; k++) begin
         chk("rr_idle_vld", 32'(rsp_valid), 32'h0);
         chk("rr_grant",    32'(req_ready), 32'(1 << (k % 4)));
         tick(); settle();
         chk("rr_en",       32'(alu_en),    32'h1);
         chk("rr_ready_ex", 32'(req_ready), 32'h0);
         tick(); settle();
         chk("rr_vld",      32'(rsp_valid), 32'h1);
         chk("rr_id",       32'(rsp_id),    32'(k % 4));
         chk("rr_data",     rsp_data,       exp_rr[k % 4]);
         chk("rr_cnt",      32'(op_count),  32'(k));
         chk("rr_ready_rs", 32'(req_ready), 32'h0);
         if (k == 4) req_valid = '0;
         tick(); settle();
      end
      chk("rr_cnt_end",   32'(op_count),  32'h5);
      chk("rr_ready_end", 32'(req_ready), 32'h0);

      // Illegal opcode on requester 2
      set_req(2, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678);
      req_valid = 4'b0100; settle();
      chk("ill_ready", 32'(req_ready), 32'h4);
      chk("ill_en_T",  32'(alu_en),    32'h0);
      tick(); req_valid = '0; settle();
      chk("ill_vld",   32'(rsp_valid), 32'h1);
      chk("ill_err",   32'(rsp_err),   32'h1);
      chk("ill_data",  rsp_data,       32'h0);
      chk("ill_id",    32'(rsp_id),    32'h2);
      chk("ill_en_T1", 32'(alu_en),    32'h0);
      tick(); settle();
      chk("ill_vld_done", 32'(rsp_valid), 32'h0);
      chk("ill_cnt",      32'(op_count),  32'h6);
      chk("ill_en_T2",    32'(alu_en),    32'h0);

      // Backpressure on a XOR from requester 0
      set_req(0, 2'b10, 32'hFFFF_0000, 32'hFF00_FF00);
      set_req(2, 2'b10, 32'hFFFF_0000, 32'hFF00_FF00);
      rsp_ready = 1'b0;
      req_valid = 4'b0001; settle();
      chk("bp_grant", 32'(req_ready), 32'h1);
      tick(); req_valid = 4'b0110; settle();
      chk("bp_en", 32'(alu_en), 32'h1);
      tick(); settle();
      for (int c = 0; c < 10; c++) begin
         chk("bp_vld",   32'(rsp_valid), 32'h1);
         chk("bp_data",  rsp_data,       32'h00FF_FF00);
         chk("bp_id",    32'(rsp_id),    32'h0);
         chk("bp_err",   32'(rsp_err),   32'h0);
         chk("bp_ready", 32'(req_ready), 32'h0);
         chk("bp_cnt",   32'(op_count),  32'h6);
         tick(); settle();
      end
      rsp_ready = 1'b1; settle();
      chk("bp_hs_vld",   32'(rsp_valid), 32'h1);
      chk("bp_hs_ready", 32'(req_ready), 32'h0);
      tick(); settle();
      chk("bp_post_vld",   32'(rsp_valid), 32'h0);
      chk("bp_post_cnt",   32'(op_count),  32'h7);
      chk("bp_post_grant", 32'(req_ready), 32'h2);
      tick(); req_valid = '0; settle();
      tick(); settle();
      chk("bp_r1_data", rsp_data,    32'hA55A_0000);
      chk("bp_r1_id",   32'(rsp_id), 32'h1);
      tick(); settle();
      chk("bp_r1_cnt", 32'(op_count), 32'h8);

      // Saturation: preload the counter near the top, then complete two responses
      set_req(2, 2'b11, 32'h0, 32'h0);
      force dut.op_count_q = 16'hFFFE;
      settle();
      release dut.op_count_q;
      for (int s = 0; s < 2; s++) begin
         req_valid = 4'b0100; settle();
         chk("sat_grant", 32'(req_ready), 32'h4);
         tick(); req_valid = '0; settle();
         chk("sat_vld", 32'(rsp_valid), 32'h1);
         tick(); settle();
         chk("sat_cnt", 32'(op_count), 32'hFFFF);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
